// File: rtl/mux1_demux4_pkg.sv
// mux1_demux4 shared constants and helpers.
// Lane k lives at outData[lane_lsb(k) +: DATA_W].
package mux1_pkg;

  localparam int MUX1_N_OUT  = 4;
  localparam int MUX1_DATA_W = 1;

  function automatic int lane_lsb(
    input int k,
    input int dataW = MUX1_DATA_W
  );
    return k * dataW;
  endfunction

  function automatic int sel_w(
    input int nOut
  );
    return (nOut > 1) ? $clog2(nOut) : 1;
  endfunction

endpackage

// File: rtl/mux1_demux4_if.sv
// Serial-in / parallel-lane bus of the demux.
// Master drives data and select, slave returns the lanes.
interface mux1_demux4_if
  import mux1_pkg::*;
#(
  parameter int DATA_W = MUX1_DATA_W,
  parameter int N_OUT  = MUX1_N_OUT,
  localparam int SEL_W = sel_w(N_OUT)
);

  logic [DATA_W-1:0]       inData;
  logic [SEL_W-1:0]        inSel;
  logic [N_OUT*DATA_W-1:0] outData;

  modport master (
    output inData,
    output inSel,
    input  outData
  );

  modport slave (
    input  inData,
    input  inSel,
    output outData
  );

endinterface

// File: rtl/mux1_demux4_lane_reg.sv
// One output lane: write-enabled register.
// Clear is asynchronous and active-high.
module lane_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mux1_demux4.sv
// Registered 1-to-N demux: inData lands in lane inSel,
// all other lanes hold. Out-of-range selects write nothing.
module mux1_demux4
  import mux1_pkg::*;
#(
  parameter int DATA_W = MUX1_DATA_W,
  parameter int N_OUT  = MUX1_N_OUT
) (
  input logic            inClock,
  input logic            inReset,
  mux1_demux4_if.slave   bus
);

  localparam int SEL_W = sel_w(N_OUT);

  logic [N_OUT-1:0]  laneWe;
  logic [DATA_W-1:0] laneQ [N_OUT];

  for (genvar k = 0; k < N_OUT; k++) begin : gLane
    assign laneWe[k] = (bus.inSel == SEL_W'(k));

    lane_reg #(
      .W (DATA_W)
    ) uLane (
      .clk (inClock),
      .clr (inReset),
      .we  (laneWe[k]),
      .d   (bus.inData),
      .q   (laneQ[k])
    );
  end

  always_comb begin
    bus.outData = '0;
    for (int k = 0; k < N_OUT; k++) begin
      bus.outData[lane_lsb(k, DATA_W) +: DATA_W] = laneQ[k];
    end
  end

endmodule

// File: tb/tb_mux1_demux4.sv
// Scoreboard bench for mux1_demux4 (default 1-bit, 4 lanes).
// Expected lanes come from a bench-side model.
module tb_mux1_demux4;
  import mux1_pkg::*;

  logic inClock;
  logic inReset;

  mux1_demux4_if bus ();

  mux1_demux4 dut (
    .inClock (inClock),
    .inReset (inReset),
    .bus     (bus)
  );

  initial inClock = 1'b0;
  always #5 inClock = ~inClock;

  int nChecks = 0;
  int nErrors = 0;

  logic [3:0] model;
  logic [3:0] sbQ [$];

  property pSelKnown;
    @(posedge inClock) disable iff (inReset)
      !$isunknown(bus.inSel);
  endproperty
  aSelKnown: assert property (pSelKnown)
    else $error("inSel unknown out of reset");

  task automatic chk(
    input string      tag,
    input logic [3:0] obs,
    input logic [3:0] exp
  );
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %b, want %b", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] apply(
    input logic [3:0] cur,
    input logic [1:0] sel,
    input logic       d
  );
    logic [3:0] nxt;
    nxt      = cur;
    nxt[sel] = d;
    return nxt;
  endfunction

  task automatic step(
    input logic [1:0] sel,
    input logic       d
  );
    logic [3:0] exp;
    @(negedge inClock);
    bus.inSel  = sel;
    bus.inData = d;
    #1;
    chk("noComb", bus.outData, model);
    model = apply(model, sel, d);
    sbQ.push_back(model);
    @(posedge inClock);
    #1;
    if (sbQ.size() == 0) begin
      chk("sbEmpty", bus.outData, 4'bxxxx);
    end else begin
      exp = sbQ.pop_front();
      chk("lane", bus.outData, exp);
    end
  endtask

  initial begin
    inReset    = 1'b1;
    bus.inData = 1'b1;
    bus.inSel  = 2'b01;
    model      = 4'b0000;

    repeat (5) begin
      @(posedge inClock);
      #1;
      chk("rstHold", bus.outData, 4'b0000);
    end

    @(negedge inClock);
    bus.inData = 1'b0;
    inReset    = 1'b0;

    for (int s = 0; s < 4; s++) begin
      step(2'(s), 1'b0);
      chk("zeroSweep", bus.outData, 4'b0000);
      step(2'(s), 1'b0);
    end

    for (int s = 0; s < 4; s++) begin
      step(2'(s), 1'b1);
      chk("oneSweep", bus.outData,
          4'((1 << (s + 1)) - 1));
      step(2'(s), 1'b1);
    end

    step(2'b10, 1'b0);
    chk("selClear", bus.outData, 4'b1011);

    @(negedge inClock);
    #2;
    inReset = 1'b1;
    #1;
    chk("asyncRst", bus.outData, 4'b0000);
    model = 4'b0000;
    #1;
    inReset = 1'b0;

    step(2'b00, 1'b1);
    step(2'b01, 1'b0);
    step(2'b10, 1'b1);
    step(2'b11, 1'b0);
    chk("perCycle", bus.outData, 4'b0101);

    for (int s = 0; s < 4; s++) begin
      step(2'(s), 1'b1);
    end
    chk("allSet", bus.outData, 4'b1111);

    @(posedge inClock);
    #2;
    inReset    = 1'b1;
    bus.inSel  = 2'b11;
    bus.inData = 1'b1;
    #1;
    chk("midRst", bus.outData, 4'b0000);
    #4;
    inReset = 1'b0;
    @(posedge inClock);
    #1;
    chk("postRst", bus.outData, 4'b1000);
    model = 4'b1000;

    step(2'b01, 1'b1);
    chk("postRst2", bus.outData, 4'b1010);

    if (sbQ.size() != 0) begin
      chk("sbLeft", 4'(sbQ.size()), 4'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             nChecks, nErrors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time %0t, limit 100000",
             $time);
    $fatal(1);
  end

endmodule

// File: doc/mux1_demux4.md
Name: mux1_demux4

Overview:
- Registered 1-to-N demultiplexer. Default is 1 bit in, 4 lanes out.
- On every clock edge, the serial input bit is written into the output lane chosen by the select input. All other lanes hold their value.
- Used in the Zigbee datapath to fan a single-bit stream out to parallel lanes, e.g. to drive a 4-bit chip/symbol collector.

Parameters:
- DATA_W, 1: width of one lane and of inData.
- N_OUT, 4: number of output lanes.
- SEL_W, $clog2(N_OUT) (=2): width of inSel. Derived, not overridden.

Ports:
- inClock  input  1  system clock; rising-edge active.
- inReset  input  1  asynchronous reset, active-high.
- inData   input  DATA_W  data to route.
- inSel    input  SEL_W  index of the destination lane.
- outData  output  N_OUT*DATA_W  registered lane outputs; lane k occupies bits [k*DATA_W +: DATA_W].

Behaviour:
- One clock, inClock. Reset is asynchronous and active-high. All state sits in flops clocked by inClock and cleared by inReset.
- Reset:
  - While inReset=1, outData = all zeros, immediately, with no clock needed.
  - Deassertion is sampled on the next rising edge.
  - Reset asserted mid-operation clears every lane at once.
- Normal operation, on each rising edge with inReset=0:
  - Lane[inSel] <= inData.
  - Every other lane keeps its previous value. This is a hold/latching demux, not zero-fill.
- Latency: 1 clock. Values of inData/inSel sampled at edge t appear on outData after edge t. There is no combinational path from inputs to outData.
- Select held constant for several cycles: the selected lane simply re-samples inData each cycle.
- Select changing every cycle: each lane captures the inData present on the edge where it was selected.
- Out-of-range select (inSel >= N_OUT, only possible when N_OUT is not a power of 2): no lane is written and all lanes hold. With the default N_OUT=4 every code 0..3 is valid.
- No handshake and no enable. A write happens every cycle outside reset.
- X on inSel while out of reset is not guaranteed to be safe. The verification engineer asserts that inSel is known whenever inReset=0.

Decomposition:
- Shared package, mux1_pkg, holds:
  - the default constants: MUX1_N_OUT=4 and MUX1_DATA_W=1;
  - a function computing the lane bit offset, lane_lsb(k) = k*DATA_W.
- Single module. One natural sub-module is lane_reg, a DATA_W-wide register with write-enable and async active-high clear, instantiated N_OUT times via generate.
- Write-enable per lane = (inSel == k).

Test Plan:
1. Reset:
   - Hold inReset=1 for 5 cycles with inData=1, inSel=2'b01 -> outData=4'b0000 throughout.
   - Assert inReset=1 asynchronously between edges -> outData goes to 0 without waiting for an edge.
2. Zero sweep:
   - After reset, inData=0; inSel steps 00,01,10,11, each held 2 cycles -> outData stays 4'b0000.
   - Each step is checked 1 cycle after the sel change.
3. One sweep:
   - inData=1; inSel steps 00,01,10,11, 2 cycles each.
   - outData after each step = 4'b0001, 4'b0011, 4'b0111, 4'b1111. Lanes hold once set.
4. Selective clear:
   - From outData=4'b1111, inData=0, inSel=2'b10 for 1 cycle -> outData=4'b1011. The other lanes are untouched.
5. Per-cycle select change:
   - Drive (inSel, inData) = (00,1), (01,0), (10,1), (11,0) on consecutive edges from outData=4'b0000 -> final outData=4'b0101.
   - Check the 1-cycle latency on each edge.
6. Reset mid-stream:
   - With outData=4'b1111, pulse inReset high for half a cycle -> outData=4'b0000 at once.
   - On the next edge after release with inSel=11, inData=1 -> outData=4'b1000.
